// File: rtl/multi_channel_wave_engine.sv
// rtl/multi_channel_wave_engine.sv - N-channel DDS waveform engine with shadowed config and mixer
module multi_channel_wave_engine #(
    parameter int CHANNELS = 2,
    parameter int PHASE_W  = 32,
    parameter int DATA_W   = 12
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       SAMP_EN,
    input  logic                       SYNC,
    input  logic                       WR_EN,
    input  logic [2:0]                 WR_CH,
    input  logic [2:0]                 WR_ADDR,
    input  logic [PHASE_W-1:0]         WR_DATA,
    input  logic                       COMMIT,
    input  logic [1:0]                 MIX_MODE,
    input  logic [2:0]                 MIX_SEL,
    output logic [CHANNELS*DATA_W-1:0] CH_OUT,
    output logic [DATA_W-1:0]          MIX_OUT,
    output logic                       VALID
);
    localparam int LOG_CH = $clog2(CHANNELS);
    localparam int SUM_W  = DATA_W + 4;
    localparam logic [DATA_W-1:0] ONES = '1;

    typedef struct packed {
        logic [PHASE_W-1:0] pinc;
        logic [DATA_W-1:0]  min_val;
        logic [DATA_W-1:0]  max_val;
        logic [1:0]         wave;
        logic [7:0]         duty;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{pinc: '0, min_val: '0, max_val: '1, wave: 2'd0, duty: 8'd128};

    cfg_t               shadow  [CHANNELS];
    cfg_t               active  [CHANNELS];
    cfg_t               cfg_now [CHANNELS];
    logic [PHASE_W-1:0] phase   [CHANNELS];
    logic [PHASE_W-1:0] ph_use  [CHANNELS];
    logic               pending;

    logic               s1_valid;
    logic [DATA_W-1:0]  s1_raw [CHANNELS];
    logic [DATA_W-1:0]  s1_min [CHANNELS];
    logic [DATA_W-1:0]  s1_max [CHANNELS];
    logic               s2_valid;
    logic [DATA_W-1:0]  s2_ch  [CHANNELS];

    logic [SUM_W-1:0]   sum;
    logic [DATA_W-1:0]  sel_val;
    logic [DATA_W-1:0]  am_val;
    logic [DATA_W-1:0]  mix_val;

    function automatic logic [DATA_W-1:0] raw_shape(input logic [DATA_W-1:0] p,
                                                    input logic [1:0] wave,
                                                    input logic [7:0] duty);
        logic [DATA_W-1:0] ramp;
        ramp = {p[DATA_W-2:0], 1'b0};
        case (wave)
            2'd0:    raw_shape = (p[DATA_W-1 -: 8] < duty) ? ONES : '0;
            2'd1:    raw_shape = p;
            2'd2:    raw_shape = p[DATA_W-1] ? ~ramp : ramp;
            default: raw_shape = ONES;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0] raw,
                                                input logic [DATA_W-1:0] lo,
                                                input logic [DATA_W-1:0] hi);
        logic [2*DATA_W-1:0] prod;
        prod = {{DATA_W{1'b0}}, hi - lo} * {{DATA_W{1'b0}}, raw};
        if (lo >= hi)
            scale = lo;
        else if (raw == ONES)
            scale = hi;
        else
            scale = lo + DATA_W'(prod >> DATA_W);
    endfunction

    // A pending commit makes the strobing sample see the shadow values directly.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            cfg_now[k] = pending ? shadow[k] : active[k];
            ph_use[k]  = SYNC ? '0 : phase[k];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pending  <= 1'b0;
            s1_valid <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                shadow[k] <= CFG_RESET;
                active[k] <= CFG_RESET;
                phase[k]  <= '0;
                s1_raw[k] <= '0;
                s1_min[k] <= '0;
                s1_max[k] <= '0;
            end
        end else begin
            s1_valid <= SAMP_EN;
            pending  <= COMMIT | (pending & ~SAMP_EN);
            for (int k = 0; k < CHANNELS; k++) begin
                if (SAMP_EN) begin
                    active[k] <= cfg_now[k];
                    phase[k]  <= ph_use[k] + cfg_now[k].pinc;
                    s1_raw[k] <= raw_shape(ph_use[k][PHASE_W-1 -: DATA_W], cfg_now[k].wave, cfg_now[k].duty);
                    s1_min[k] <= cfg_now[k].min_val;
                    s1_max[k] <= cfg_now[k].max_val;
                end else if (SYNC) begin
                    phase[k] <= '0;
                end
                if (WR_EN && WR_CH == 3'(k)) begin
                    case (WR_ADDR)
                        3'd0: shadow[k].pinc    <= WR_DATA;
                        3'd1: shadow[k].min_val <= WR_DATA[DATA_W-1:0];
                        3'd2: shadow[k].max_val <= WR_DATA[DATA_W-1:0];
                        3'd3: begin
                            shadow[k].wave <= WR_DATA[1:0];
                            shadow[k].duty <= WR_DATA[15:8];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    generate
        if (CHANNELS > 1) begin : g_am
            logic [2*DATA_W-1:0] am_prod;
            assign am_prod = {{DATA_W{1'b0}}, s2_ch[1]} * {{DATA_W{1'b0}}, s2_ch[0]};
            assign am_val  = DATA_W'(am_prod >> DATA_W);
        end else begin : g_no_am
            assign am_val = '0;
        end
    endgenerate

    always_comb begin
        sum     = '0;
        sel_val = '0;
        mix_val = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            sum = sum + SUM_W'(s2_ch[k]);
            if (MIX_SEL == 3'(k))
                sel_val = s2_ch[k];
        end
        case (MIX_MODE)
            2'd0:    mix_val = sel_val;
            2'd1:    mix_val = DATA_W'(sum >> LOG_CH);
            2'd2:    mix_val = am_val;
            default: mix_val = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s2_valid <= 1'b0;
            VALID    <= 1'b0;
            CH_OUT   <= '0;
            MIX_OUT  <= '0;
            for (int k = 0; k < CHANNELS; k++)
                s2_ch[k] <= '0;
        end else begin
            s2_valid <= s1_valid;
            VALID    <= s2_valid;
            for (int k = 0; k < CHANNELS; k++) begin
                if (s1_valid)
                    s2_ch[k] <= scale(s1_raw[k], s1_min[k], s1_max[k]);
                if (s2_valid)
                    CH_OUT[k*DATA_W +: DATA_W] <= s2_ch[k];
            end
            if (s2_valid)
                MIX_OUT <= mix_val;
        end
    end

endmodule

// File: doc/multi_channel_wave_engine.md
Name: multi_channel_wave_engine

Overview:
Parametrised N-channel waveform synthesiser with DDS phase accumulators and glitch-free shadowed configuration. It generates square, sawtooth, triangle or DC samples per channel, scales each between a per-channel min and max, and produces a mixed output. It sits between the front-panel/keyboard control logic and the DAC serialiser. It replaces the fixed two-channel wave_mux arrangement.

Parameters:
CHANNELS, 2, number of channels; power of two in {1,2,4,8}
PHASE_W, 32, phase accumulator width
DATA_W, 12, sample width (DAC resolution)

Ports:
CLK  input  1  system clock
RST  input  1  synchronous, active-high reset
SAMP_EN  input  1  one-cycle sample strobe
SYNC  input  1  zero all phase accumulators
WR_EN  input  1  config write strobe
WR_CH  input  3  target channel
WR_ADDR  input  3  register: 0 PINC, 1 MIN, 2 MAX, 3 WAVE[1:0]/DUTY[15:8]
WR_DATA  input  PHASE_W  write data
COMMIT  input  1  arm shadow-to-active copy
MIX_MODE  input  2  0 select, 1 average, 2 AM (ch1 scaled by ch0), 3 zero
MIX_SEL  input  3  channel for select mode
CH_OUT  output  CHANNELS*DATA_W  per-channel samples; ch k at [k*DATA_W +: DATA_W]
MIX_OUT  output  DATA_W  mixed sample
VALID  output  1  one-cycle pulse when CH_OUT/MIX_OUT update

Behaviour:
- Reset (when RST=1 at a CLK edge): phases 0, PINC 0, MIN 0, MAX 2^DATA_W-1, WAVE square (0), DUTY 128, in both shadow and active copies. COMMIT pending flag cleared. CH_OUT 0, MIX_OUT 0, VALID 0. Pipeline contents are discarded.
- Writes: if WR_EN=1, WR_DATA is written to the shadow register (WR_CH, WR_ADDR). MIN and MAX take the low DATA_W bits. Writes with WR_CH >= CHANNELS or WR_ADDR > 3 are ignored.
- COMMIT sets a pending flag. On the next SAMP_EN, all shadow registers are copied to active, the flag is cleared, and that sample already uses the new values. A write in the same cycle as COMMIT is included in the commit.
- Phase: on SAMP_EN, each channel samples its pre-increment phase, then phase <= phase + PINC, modulo 2^PHASE_W.
- SYNC=1: all phases are forced to 0. If SYNC coincides with SAMP_EN, the sample uses phase 0 and the stored phase becomes PINC. SYNC without SAMP_EN produces no sample.
- Raw shape. Let P = phase[PHASE_W-1 -: DATA_W] and D = phase[PHASE_W-1 -: 8].
  - Square: all ones if D < DUTY, else 0. DUTY 0 gives constant low.
  - Sawtooth: P.
  - Triangle: P[MSB]=0 gives {P[DATA_W-2:0],0}; otherwise the bitwise inverse of that.
  - DC: all ones.
- Scale:
  - If MIN >= MAX, the sample is MIN.
  - Otherwise, raw all ones gives MAX exactly.
  - Otherwise, the sample is MIN + (((MAX-MIN)*raw) >> DATA_W). Use a 2*DATA_W-bit product.
- Mix:
  - Select: channel MIX_SEL; an out-of-range value gives 0.
  - Average: sum of all channels >> log2(CHANNELS).
  - AM: (ch1*ch0) >> DATA_W; with CHANNELS=1 this gives 0.
  - Zero: 0.
- Pipeline: stage 1 phase/raw, stage 2 scale, stage 3 mix/register. VALID rises exactly 3 cycles after SAMP_EN.
- Back-to-back SAMP_EN every cycle is supported at full throughput.
- Outputs hold between VALID pulses.
- MIX_MODE and MIX_SEL are sampled in stage 3.

Test Plan:
- Reset, then SAMP_EN at cycle 0 (ch0 defaults: square, DUTY 128, phase 0) -> VALID at cycle 3; ch0=4095, MIX_OUT (select 0)=4095. Before that: VALID=0 and outputs 0.
- ch0 sawtooth, PINC=0x1000_0000, MIN 0, MAX 4095, committed; 17 strobes -> ch0 sequence 0,255,511,767,… ; the 17th sample returns to 0.
- Shadow MAX=2000 written without COMMIT -> ch0 unchanged across 4 samples. COMMIT, then SAMP_EN -> that sample already uses MAX 2000 (DC wave gives 2000).
- MIN=3000, MAX=1000, any wave -> ch0 constant 3000. Writes to WR_CH=5 -> no register changes.
- ch0 DC MAX 4000, ch1 DC MAX 2000:
  - average mode -> MIX_OUT 3000.
  - AM mode -> (2000*4000)>>12 = 1953.
- SYNC with SAMP_EN after 5 PINC steps -> sample phase 0. RST asserted one cycle after SAMP_EN -> no VALID pulse and all outputs 0.
